// File: rtl/fpu_pkg.sv
// fpu_pkg: constants and types shared by the FP issue controller.
//   - major opcodes of the FP instruction classes it accepts
//   - OP-FP funct5 values and the FALU operation codes they map to
//   - instruction-kind codes produced by the classifier
//   - controller state enum
package fpu_pkg;

  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_FLOAD  = 7'b0000111;
  localparam logic [6:0] OP_FSTORE = 7'b0100111;

  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SUB  = 5'b00001;
  localparam logic [4:0] F5_MUL  = 5'b00010;
  localparam logic [4:0] F5_DIV  = 5'b00011;
  localparam logic [4:0] F5_SQRT = 5'b00100;
  localparam logic [4:0] F5_MIN  = 5'b00101;
  localparam logic [4:0] F5_MAX  = 5'b00110;
  localparam logic [4:0] F5_EQ   = 5'b10100;
  localparam logic [4:0] F5_LT   = 5'b10101;
  localparam logic [4:0] F5_LE   = 5'b10110;

  // Code 0 means "no FALU operation"; the compares (8..10) write the integer file.
  localparam logic [4:0] FOP_NONE = 5'd0;
  localparam logic [4:0] FOP_ADD  = 5'd1;
  localparam logic [4:0] FOP_SUB  = 5'd2;
  localparam logic [4:0] FOP_MUL  = 5'd3;
  localparam logic [4:0] FOP_DIV  = 5'd4;
  localparam logic [4:0] FOP_SQRT = 5'd5;
  localparam logic [4:0] FOP_MIN  = 5'd6;
  localparam logic [4:0] FOP_MAX  = 5'd7;
  localparam logic [4:0] FOP_EQ   = 5'd8;
  localparam logic [4:0] FOP_LT   = 5'd9;
  localparam logic [4:0] FOP_LE   = 5'd10;

  localparam logic [1:0] KIND_FP    = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;
  localparam logic [1:0] KIND_NONE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_MEM,
    ST_WB
  } state_t;

  // Unmapped funct5 values return FOP_NONE, which the classifier treats as illegal.
  function automatic logic [4:0] funct5_to_op(input logic [4:0] f5);
    case (f5)
      F5_ADD:  return FOP_ADD;
      F5_SUB:  return FOP_SUB;
      F5_MUL:  return FOP_MUL;
      F5_DIV:  return FOP_DIV;
      F5_SQRT: return FOP_SQRT;
      F5_MIN:  return FOP_MIN;
      F5_MAX:  return FOP_MAX;
      F5_EQ:   return FOP_EQ;
      F5_LT:   return FOP_LT;
      F5_LE:   return FOP_LE;
      default: return FOP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fpu_instr_classify.sv
// fpu_instr_classify: combinational decode of one FP instruction word.
// Ports:
//   instr   in  32  raw instruction
//   kind    out 2   KIND_FP / KIND_LOAD / KIND_STORE / KIND_NONE
//   falu_op out 5   FALU operation code (0 unless a mapped OP-FP)
//   imm     out 32  sign-extended load/store offset (0 otherwise)
//   illegal out 1   opcode or funct5 not supported
module fpu_instr_classify
  import fpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  kind,
  output logic [4:0]  falu_op,
  output logic [31:0] imm,
  output logic        illegal
);

  // Register and rounding fields are latched by the controller, not decoded here.
  logic unused_fields;
  assign unused_fields = ^instr[19:12];

  always_comb begin
    kind    = KIND_NONE;
    falu_op = FOP_NONE;
    imm     = '0;
    illegal = 1'b1;
    case (instr[6:0])
      OP_FP: begin
        kind    = KIND_FP;
        falu_op = funct5_to_op(instr[31:27]);
        illegal = (falu_op == FOP_NONE);
      end
      OP_FLOAD: begin
        kind    = KIND_LOAD;
        imm     = {{20{instr[31]}}, instr[31:20]};
        illegal = 1'b0;
      end
      OP_FSTORE: begin
        kind    = KIND_STORE;
        imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-issue sequencer for the single-precision FP unit.
// Accepts one instruction in IDLE, then drives the FALU (ISSUE/WAIT), the
// data-memory port (MEM) and the register-file writeback strobe (WB) in order.
// Optional feature macro: FPU_ISSUE_TIMEOUT_EN -- bounds WAIT to FALU_TIMEOUT
// cycles and pulses falu_timeout on abort; otherwise falu_timeout is tied 0.
// Ports:
//   clk, rst_n (async active-low)
//   instr_valid/instr in, instr_ready out (high only in IDLE)
//   rs1_addr/rs2_addr/rd_addr/rm/fmt out   latched instruction fields
//   falu_start/falu_op out, falu_done in   FALU handshake
//   base_data in; mem_req/mem_we/mem_addr/mem_width out; mem_ack in
//   wb_en/wb_int out                       writeback strobe and target file
//   illegal_instr/falu_timeout out         one-cycle event pulses
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int FALU_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [2:0]  rm,
  output logic [1:0]  fmt,
  output logic        falu_start,
  output logic [4:0]  falu_op,
  input  logic        falu_done,
  input  logic [31:0] base_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_width,
  input  logic        mem_ack,
  output logic        wb_en,
  output logic        wb_int,
  output logic        illegal_instr,
  output logic        falu_timeout
);

  state_t      state;
  logic [1:0]  dec_kind;
  logic [4:0]  dec_op;
  logic [31:0] dec_imm;
  logic        dec_illegal;

  fpu_instr_classify u_classify (
    .instr   (instr),
    .kind    (dec_kind),
    .falu_op (dec_op),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign instr_ready = (state == ST_IDLE);

`ifdef FPU_ISSUE_TIMEOUT_EN
  logic [31:0] wait_cnt;
`else
  assign falu_timeout = 1'b0;
  wire unused_timeout_cfg = (FALU_TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rs1_addr      <= '0;
      rs2_addr      <= '0;
      rd_addr       <= '0;
      rm            <= '0;
      fmt           <= '0;
      falu_start    <= 1'b0;
      falu_op       <= FOP_NONE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_width     <= '0;
      wb_en         <= 1'b0;
      wb_int        <= 1'b0;
      illegal_instr <= 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
      falu_timeout  <= 1'b0;
      wait_cnt      <= '0;
`endif
    end else begin
      // Event outputs are single-cycle pulses.
      falu_start    <= 1'b0;
      wb_en         <= 1'b0;
      illegal_instr <= 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
      falu_timeout  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            if (dec_illegal) begin
              // Rejected words leave every latched field untouched.
              illegal_instr <= 1'b1;
            end else begin
              rs1_addr <= instr[19:15];
              rs2_addr <= instr[24:20];
              rd_addr  <= instr[11:7];
              rm       <= instr[14:12];
              fmt      <= instr[26:25];
              falu_op  <= dec_op;
              if (dec_kind == KIND_FP) begin
                falu_start <= 1'b1;
                state      <= ST_ISSUE;
              end else begin
                // Address is formed once here and held for the whole access.
                mem_req   <= 1'b1;
                mem_we    <= (dec_kind == KIND_STORE);
                mem_addr  <= base_data + dec_imm;
                mem_width <= instr[14:12];
                state     <= ST_MEM;
              end
            end
          end
        end
        ST_ISSUE: begin
          // falu_done is deliberately not looked at until WAIT.
`ifdef FPU_ISSUE_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (falu_done) begin
            wb_en  <= 1'b1;
            wb_int <= (falu_op >= FOP_EQ);
            state  <= ST_WB;
          end
`ifdef FPU_ISSUE_TIMEOUT_EN
          else if (wait_cnt == 32'(FALU_TIMEOUT - 1)) begin
            falu_timeout <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        ST_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= ST_IDLE;
            end else begin
              wb_en  <= 1'b1;
              wb_int <= 1'b0;
              state  <= ST_WB;
            end
          end
        end
        ST_WB: begin
          wb_int <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Single-issue sequencer for the single-precision FP unit. Accepts one 32-bit FP instruction at a time (OP-FP, FLW-class load, FSW-class store), classifies it, and drives the multi-cycle FALU, the data-memory port and the FP register-file writeback in order. It sits between instruction fetch and the FALU/register file. It holds off the next instruction until the current one retires.

## Interface
- `FALU_TIMEOUT`, default 64: maximum number of WAIT cycles before an FALU op is aborted (only used with the timeout feature).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction presented.
- `instr`  in  32  RISC-V F encoding.
- `instr_ready`  out  1  controller can accept; high only in IDLE.
- `rs1_addr`, `rs2_addr`, `rd_addr`  out  5  latched register fields.
- `rm`  out  3  latched `instr[14:12]`.
- `fmt`  out  2  latched `instr[26:25]`.
- `falu_start`  out  1  one-cycle start pulse.
- `falu_op`  out  5  FALU operation code, held from ISSUE through WAIT.
- `falu_done`  in  1  FALU result valid.
- `base_data`  in  32  integer rs1 value used for the address.
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  1 = store.
- `mem_addr`  out  32  `base_data + imm`.
- `mem_width`  out  3  `instr[14:12]`.
- `mem_ack`  in  1  memory accepted or completed.
- `wb_en`  out  1  one-cycle writeback strobe.
- `wb_int`  out  1  writeback targets the integer file (feq/flt/fle).
- `illegal_instr`  out  1  one-cycle pulse on an unsupported encoding.
- `falu_timeout`  out  1  one-cycle pulse on abort (tied 0 without the macro).

## Operation
- States: IDLE, ISSUE, WAIT, MEM, WB.
- **IDLE**
  - `instr_ready` = 1.
  - When `instr_valid` is high, latch `instr` and all fields, then classify on `instr[6:0]`.
  - 1010011 with a valid funct5 → ISSUE.
  - 0000111 → MEM with `mem_we` = 0, imm = sext(`instr[31:20]`).
  - 0100111 → MEM with `mem_we` = 1, imm = sext({`instr[31:25]`, `instr[11:7]`}).
  - Any other opcode, or an unmapped funct5 → pulse `illegal_instr` next cycle and stay in IDLE. No other output changes.
- **funct5 → `falu_op`:** 00000→1 add, 00001→2 sub, 00010→3 mul, 00011→4 div, 00100→5 sqrt, 00101→6 min, 00110→7 max, 10100→8 eq, 10101→9 lt, 10110→10 le. All others are illegal.
- **ISSUE:** `falu_start` = 1 for exactly one cycle, then WAIT. `falu_done` is ignored in ISSUE.
- **WAIT:** on `falu_done` → WB. `wb_int` = 1 for codes 8–10, else 0.
- **MEM**
  - `mem_req` is high from MEM entry until `mem_ack` is sampled high.
  - `mem_addr` is computed once at MEM entry from `base_data` and held. Arithmetic is 32-bit modulo 2^32 with no overflow detect.
  - On ack: load → WB; store → IDLE.
- **WB:** `wb_en` = 1 for one cycle with `rd_addr` valid, then IDLE.
- **Reset values:** state IDLE; all registered outputs 0; `instr_ready` = 1 after reset deassertion.
- **Reset mid-operation:** reset asserted in any state returns asynchronously to IDLE and drops `mem_req`/`falu_start`/`wb_en`. No writeback occurs for the in-flight instruction.

## Timing
- Accept edge = cycle 0.
- **OP-FP:** `falu_start` in cycle 1. If `falu_done` arrives in cycle k ≥ 2, `wb_en` is in cycle k+1 and `instr_ready` returns in cycle k+2.
- **Load:** `mem_req` from cycle 1. If ack arrives in cycle a, `wb_en` is in cycle a+1.
- **Store:** ack in cycle a → IDLE in cycle a+1, with no `wb_en`.
- **Illegal:** pulse in cycle 1, `instr_ready` stays high. A back-to-back accept in cycle 1 is allowed.
- `falu_done` or `mem_ack` arriving in a state that does not wait for it is ignored.

## Configuration
- **`FPU_ISSUE_TIMEOUT_EN` defined:** a counter runs in WAIT. When it reaches `FALU_TIMEOUT` cycles with no `falu_done`, pulse `falu_timeout`, return to IDLE and suppress writeback. The counter clears on WAIT entry. If `falu_done` arrives in the same cycle the count is reached, done wins.
- **Undefined:** no counter, WAIT is unbounded, and `falu_timeout` is constant 0.

## Structure
- The shared package `fpu_pkg` holds:
  - the opcode constants (OP_FP, OP_FLOAD, OP_FSTORE);
  - the funct5 constants;
  - the `falu_op` codes 1–10;
  - the state enum.
- One sub-module, `fpu_instr_classify`: combinational decode of `instr` → {kind, `falu_op`, imm, illegal}, instantiated once in front of the IDLE latch.

## Test plan
- **fadd:** `instr` = 0x003100D3 (funct5 0, rs1=2, rs2=3, rd=1); `falu_done` 3 cycles after start → `falu_op` = 1, `wb_en` in cycle 5 with `rd_addr` = 1, `wb_int` = 0.
- **feq:** funct5 10100; done in cycle 2 → `falu_op` = 8, `wb_int` = 1, `wb_en` in cycle 3.
- **Load:** imm = 0xFFC, `base_data` = 0x1000; ack in cycle 4 → `mem_addr` = 0x0FFC, `mem_we` = 0, `mem_req` high cycles 1–4, `wb_en` in cycle 5.
- **Store:** imm = 8, `base_data` = 0xFFFFFFFC → `mem_addr` = 0x00000004 (wrap), `mem_we` = 1, no `wb_en`.
- **Illegal:** opcode 0110011, then funct5 11111 → `illegal_instr` 1-cycle pulse, `instr_ready` held 1.
- **Boundaries:** reset asserted during WAIT → all outputs 0 immediately, and a late `falu_done` causes no `wb_en`. With `FPU_ISSUE_TIMEOUT_EN` and `FALU_TIMEOUT` = 4, withholding `falu_done` → `falu_timeout` pulse, IDLE, no `wb_en`.
